ramspx: RTL



---
 rtl/ramspx_pkg.sv | 23 ++
 rtl/ramspx_init.sv | 43 ++++
 rtl/ramspx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ramspx_pkg.sv
// Shared constants and the lane-merge helper for the ramspx single-port RAM.
package ramspx_pkg;

  localparam int RAMSPX_NOCHANGE = 0;
  localparam int RAMSPX_WRFIRST  = 1;
  localparam int RAMSPX_RDFIRST  = 2;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int RAMSPX_MAXW = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic [RAMSPX_MAXW-1:0] lane_merge(
    input logic [RAMSPX_MAXW-1:0] old_w,
    input logic [RAMSPX_MAXW-1:0] new_w,
    input logic [RAMSPX_MAXW-1:0] bmask
  );
    return (old_w & ~bmask) | (new_w & bmask);
  endfunction

endpackage

// File: rtl/ramspx_init.sv
// Post-reset zero-fill sequencer: walks every address once, one word per cycle.
// Latency: busy for exactly 2**AW cycles after reset release; no backpressure.
// Backpressure: none, owns the array write port while busy.
module ramspx_init
  import ramspx_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic          o_busy,
  output logic          o_we,
  output logic [AW-1:0] o_addr
);

  logic [1:0]    r_state;
  logic [AW-1:0] r_cnt;

  // IDLE already writes address 0 so the fill takes exactly 2**AW cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt   <= r_cnt + AW'(1);
          r_state <= (&r_cnt) ? ST_DONE : ST_CLEAR;
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (&r_cnt) r_state <= ST_DONE;
        end
        default: r_state <= ST_DONE;
      endcase
    end
  end

  assign o_busy = (r_state != ST_DONE);
  assign o_we   = o_busy;
  assign o_addr = r_cnt;

endmodule

// File: rtl/ramspx.sv
// Single-port RAM with lane write mask, MODE read-during-write, optional OREG stage.
// Latency: 1 cycle (OREG=0) or 2 cycles (OREG=1); busy blocks access during init.
// Optional zero-fill after reset when RAMSPX_INIT_EN is defined.
module ramspx
  import ramspx_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 10,
  parameter int BW   = 8,
  parameter int MODE = 0,
  parameter int OREG = 0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en,
  input  logic             we,
  input  logic [DW/BW-1:0] wmask,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  output logic             dvalid,
  output logic             busy
);

  localparam int NL    = DW / BW;
  localparam int DEPTH = 2 ** AW;

  generate
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("ramspx: MODE must be 0, 1 or 2");
    end
    if ((DW % BW) != 0) begin : g_bad_bw
      $error("ramspx: DW must be a multiple of BW");
    end
    if (DW > RAMSPX_MAXW) begin : g_bad_dw
      $error("ramspx: DW exceeds lane_merge width");
    end
  endgenerate

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_busy;
  logic          w_init_we;
  logic [AW-1:0] w_init_addr;

`ifdef RAMSPX_INIT_EN
  ramspx_init #(.AW(AW)) u_init (
    .i_clk   (clk),
    .i_rst_n (nreset),
    .o_busy  (w_busy),
    .o_we    (w_init_we),
    .o_addr  (w_init_addr)
  );
`else
  assign w_busy      = 1'b0;
  assign w_init_we   = 1'b0;
  assign w_init_addr = '0;
`endif

  logic          w_acc;
  logic          w_wr;
  logic          w_rd;
  logic [DW-1:0] w_old;
  logic [DW-1:0] w_bmask;
  logic [DW-1:0] w_merged;

  assign w_acc = en & ~w_busy;
  assign w_wr  = w_acc & we;
  assign w_rd  = w_acc & ~we;
  assign w_old = r_mem[addr];

  generate
    for (genvar i = 0; i < NL; i++) begin : g_lane
      assign w_bmask[i*BW +: BW] = {BW{wmask[i]}};
    end
  endgenerate

  assign w_merged = DW'(lane_merge(RAMSPX_MAXW'(w_old), RAMSPX_MAXW'(din),
                                   RAMSPX_MAXW'(w_bmask)));

  // Array is deliberately unreset; the init sequencer takes priority over users.
  always_ff @(posedge clk) begin
    if (w_init_we)
      r_mem[w_init_addr] <= '0;
    else if (w_wr)
      r_mem[addr] <= w_merged;
  end

  logic [DW-1:0] r_dout1;
  logic          r_vld1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dout1 <= '0;
      r_vld1  <= 1'b0;
    end else if (w_rd) begin
      r_dout1 <= w_old;
      r_vld1  <= 1'b1;
    end else if (w_wr && MODE == RAMSPX_WRFIRST) begin
      r_dout1 <= w_merged;
      r_vld1  <= 1'b1;
    end else if (w_wr && MODE == RAMSPX_RDFIRST) begin
      r_dout1 <= w_old;
      r_vld1  <= 1'b1;
    end else begin
      r_vld1  <= 1'b0;
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic [DW-1:0] r_dout2;
      logic          r_vld2;

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          r_dout2 <= '0;
          r_vld2  <= 1'b0;
        end else begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_dout2 <= r_dout1;
        end
      end

      assign dout   = r_dout2;
      assign dvalid = r_vld2;
    end else begin : g_noreg
      assign dout   = r_dout1;
      assign dvalid = r_vld1;
    end
  endgenerate

  assign busy = w_busy;

endmodule
